// File: rtl/cpu_defs.sv
// Shared types and encodings for the pre-memory stage and its neighbours.
package cpu_defs;

    localparam int LOAD_OP_W  = 7;
    localparam int STORE_OP_W = 5;

    // load_op one-hot bit positions
    localparam int LD_LB  = 0;
    localparam int LD_LBU = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 4;
    localparam int LD_LWL = 5;
    localparam int LD_LWR = 6;

    // store_op one-hot bit positions
    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;
    localparam int ST_SWL = 3;
    localparam int ST_SWR = 4;

    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic                  valid;
        logic [LOAD_OP_W-1:0]  load_op;
        logic [STORE_OP_W-1:0] store_op;
        logic [2:0]            c0_op;      // [2] mfc0, [1] mtc0, [0] eret
        logic [7:0]            c0_addr;
        logic                  res_from_mem;
        logic                  res_to_mem;
        logic                  rf_we;
        logic [31:0]           alu_result;
        logic [4:0]            dest;
        logic [31:0]           final_result;
        logic [31:0]           pc;
        exception_t            exception;
    } es_to_pms_bus_t;

    typedef struct packed {
        logic                  valid;
        logic                  cancel;
        logic [LOAD_OP_W-1:0]  load_op;
        logic [STORE_OP_W-1:0] store_op;
        logic [2:0]            c0_op;
        logic [7:0]            c0_addr;
        logic                  res_from_mem;
        logic                  res_to_mem;
        logic                  rf_we;
        logic [31:0]           alu_result;
        logic [4:0]            dest;
        logic [31:0]           final_result;
        logic [31:0]           pc;
        exception_t            exception;
    } pms_to_ms_bus_t;

    typedef struct packed {
        logic        op_mfc0;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } pms_forward_bus_t;

    typedef struct packed {
        logic eret;
        logic ex;
    } pipeline_flush_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } pms_state_t;

endpackage

// File: rtl/mem_wgen.sv
// Combinational data-SRAM address-phase generator: size, word/byte address,
// byte strobes, lane-replicated write data and address-alignment exception.
module mem_wgen
    import cpu_defs::*;
(
    input  logic [LOAD_OP_W-1:0]  load_op,
    input  logic [STORE_OP_W-1:0] store_op,
    input  logic [31:0]           vaddr,
    input  logic [31:0]           rt,
    output logic [1:0]            size,
    output logic [31:0]           addr,
    output logic [3:0]            wstrb,
    output logic [31:0]           wdata,
    output exception_t            align_ex
);

    // Decode access width, strobes, shifted write data and misalignment.
    always_comb begin
        size     = 2'd2;
        addr     = {vaddr[31:2], 2'b00};
        wstrb    = 4'b0000;
        wdata    = rt;
        align_ex = '0;

        if (load_op[LD_LB] | load_op[LD_LBU] | store_op[ST_SB]) begin
            size = 2'd0;
            addr = vaddr;
        end else if (load_op[LD_LH] | load_op[LD_LHU] | store_op[ST_SH]) begin
            size = 2'd1;
            addr = vaddr;
        end

        if (store_op[ST_SB]) begin
            wstrb = 4'b0001 << vaddr[1:0];
            wdata = {4{rt[7:0]}};
        end else if (store_op[ST_SH]) begin
            wstrb = vaddr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt[15:0]}};
        end else if (store_op[ST_SW]) begin
            wstrb = 4'b1111;
        end else if (store_op[ST_SWL]) begin
            case (vaddr[1:0])
                2'd0:    begin wstrb = 4'b0001; wdata = rt >> 24; end
                2'd1:    begin wstrb = 4'b0011; wdata = rt >> 16; end
                2'd2:    begin wstrb = 4'b0111; wdata = rt >> 8;  end
                default: begin wstrb = 4'b1111; wdata = rt;       end
            endcase
        end else if (store_op[ST_SWR]) begin
            case (vaddr[1:0])
                2'd0:    begin wstrb = 4'b1111; wdata = rt;       end
                2'd1:    begin wstrb = 4'b1110; wdata = rt << 8;  end
                2'd2:    begin wstrb = 4'b1100; wdata = rt << 16; end
                default: begin wstrb = 4'b1000; wdata = rt << 24; end
            endcase
        end

        // Unaligned LWL/LWR/SWL/SWR are legal and never trap.
        if ((load_op[LD_LH] | load_op[LD_LHU]) & vaddr[0]) begin
            align_ex = '{ex: 1'b1, exccode: EXCCODE_ADEL, badvaddr: vaddr};
        end else if (store_op[ST_SH] & vaddr[0]) begin
            align_ex = '{ex: 1'b1, exccode: EXCCODE_ADES, badvaddr: vaddr};
        end else if (load_op[LD_LW] & (|vaddr[1:0])) begin
            align_ex = '{ex: 1'b1, exccode: EXCCODE_ADEL, badvaddr: vaddr};
        end else if (store_op[ST_SW] & (|vaddr[1:0])) begin
            align_ex = '{ex: 1'b1, exccode: EXCCODE_ADES, badvaddr: vaddr};
        end
    end

endmodule

// File: rtl/pms_stage.sv
// Pre-memory stage: holds one instruction between EXE and MEM, issues the
// data-SRAM address phase, and keeps a request alive until it is accepted
// even when a flush arrives mid-handshake (the instruction then reaches MEM
// marked cancel so MEM can drop the matching data response).
module pms_stage
    import cpu_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  es_to_pms_bus_t   es_to_pms_bus,
    output logic             pms_allowin,
    input  logic             ms_allowin,
    output pms_to_ms_bus_t   pms_to_ms_bus,
    input  logic             wr_disable,
    output logic             pms_wr_disable,
    output pms_forward_bus_t pms_forward_bus,
    input  pipeline_flush_t  pipeline_flush,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok
);

    es_to_pms_bus_t bus_r;
    logic           pms_valid;
    logic           cancel_r;
    pms_state_t     state;

    exception_t     align_ex;
    exception_t     ex_final;
    logic           mem_op;
    logic           need_req;
    logic           flush;
    logic           req;
    logic           hold_on_flush;
    logic           cancel_now;
    logic           ready_go;
    logic           leave;

    mem_wgen u_wgen (
        .load_op  (bus_r.load_op),
        .store_op (bus_r.store_op),
        .vaddr    (bus_r.alu_result),
        .rt       (bus_r.final_result),
        .size     (data_sram_size),
        .addr     (data_sram_addr),
        .wstrb    (data_sram_wstrb),
        .wdata    (data_sram_wdata),
        .align_ex (align_ex)
    );

    assign ex_final = bus_r.exception.ex ? bus_r.exception : align_ex;
    assign mem_op   = (|bus_r.load_op) | (|bus_r.store_op);
    assign need_req = pms_valid & mem_op & ~ex_final.ex;
    assign flush    = pipeline_flush.eret | pipeline_flush.ex;

    // Request generation: once raised, req stays high until addr_ok.
    always_comb begin
        req = 1'b0;
        case (state)
            S_IDLE:  req = need_req & ~wr_disable & ~flush;
            S_WAIT:  req = 1'b1;
            default: req = 1'b0;
        endcase
    end

    // A flush cannot abandon a request already presented and not yet accepted.
    assign hold_on_flush = (state == S_WAIT) | ((state == S_IDLE) & req & ~data_sram_addr_ok);
    assign cancel_now    = cancel_r | (flush & hold_on_flush);
    assign ready_go      = pms_valid & (~need_req | (state == S_ACK) | (req & data_sram_addr_ok));
    assign pms_allowin   = ~pms_valid | (ready_go & ms_allowin);
    assign leave         = ready_go & ms_allowin;

    assign data_sram_req  = req;
    assign data_sram_wr   = pms_valid & (|bus_r.store_op);
    assign pms_wr_disable = pms_valid & (ex_final.ex | bus_r.c0_op[0]);

    // Control state: valid bit, handshake FSM and cancel marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            pms_valid <= 1'b0;
            state     <= S_IDLE;
            cancel_r  <= 1'b0;
        end else if (flush & ~hold_on_flush) begin
            pms_valid <= 1'b0;
            state     <= S_IDLE;
            cancel_r  <= 1'b0;
        end else begin
            if (pms_allowin) begin
                pms_valid <= es_to_pms_bus.valid & ~flush;
            end
            if (leave) begin
                cancel_r <= 1'b0;
            end else if (flush) begin
                cancel_r <= 1'b1;
            end
            case (state)
                S_IDLE, S_WAIT: begin
                    if (req & data_sram_addr_ok) begin
                        state <= ms_allowin ? S_IDLE : S_ACK;
                    end else if (req) begin
                        state <= S_WAIT;
                    end
                end
                S_ACK: begin
                    if (ms_allowin) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Instruction payload register; data only, so no reset.
    always_ff @(posedge clk) begin
        if (es_to_pms_bus.valid & pms_allowin) begin
            bus_r <= es_to_pms_bus;
        end
    end

    // Assemble the MEM-bound bus; a cancelled instruction must not retire.
    always_comb begin
        pms_to_ms_bus              = '0;
        pms_to_ms_bus.valid        = pms_valid & ready_go;
        pms_to_ms_bus.cancel       = cancel_now;
        pms_to_ms_bus.load_op      = bus_r.load_op;
        pms_to_ms_bus.store_op     = bus_r.store_op;
        pms_to_ms_bus.c0_op        = bus_r.c0_op;
        pms_to_ms_bus.c0_addr      = bus_r.c0_addr;
        pms_to_ms_bus.res_from_mem = bus_r.res_from_mem;
        pms_to_ms_bus.res_to_mem   = bus_r.res_to_mem;
        pms_to_ms_bus.rf_we        = bus_r.rf_we & ~cancel_now;
        pms_to_ms_bus.alu_result   = bus_r.alu_result;
        pms_to_ms_bus.dest         = bus_r.dest;
        pms_to_ms_bus.final_result = bus_r.final_result;
        pms_to_ms_bus.pc           = bus_r.pc;
        pms_to_ms_bus.exception    = cancel_now ? '0 : ex_final;
    end

    // Bypass information for ID, suppressed when the stage is empty.
    always_comb begin
        pms_forward_bus              = '0;
        pms_forward_bus.op_mfc0      = pms_valid & bus_r.c0_op[2];
        pms_forward_bus.res_from_mem = pms_valid & bus_r.res_from_mem;
        pms_forward_bus.dest         = pms_valid ? bus_r.dest : 5'd0;
        pms_forward_bus.final_result = pms_valid ? bus_r.final_result : 32'd0;
    end

endmodule
